// File: rtl/crc8_chk_calc.sv
// rtl/crc8_chk_calc.sv - single-byte MSB-first CRC-8 update; CRC_CHK_CALC_OUT_REG_EN adds an output flop
// The CRC is linear in crc_in ^ data_in, so the update is an XOR of per-bit columns fixed by POLY.
module crc8_chk_calc #(
    parameter logic [7:0] POLY = 8'h07
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    typedef logic [7:0][7:0] col_t;

    // Column i is the CRC of a lone 1 in bit i, obtained by running the shift register 8 times.
    function automatic col_t crc_columns(input logic [7:0] poly);
        col_t       cols;
        logic [7:0] c;
        for (int i = 0; i < 8; i++) begin
            c = 8'h00;
            c[i] = 1'b1;
            for (int k = 0; k < 8; k++) begin
                c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
            end
            cols[i] = c;
        end
        return cols;
    endfunction

    localparam col_t COLS = crc_columns(POLY);

    logic [7:0] folded;
    logic [7:0] crc_next;

    always_comb begin
        folded   = crc_in ^ data_in;
        crc_next = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (folded[i]) begin
                crc_next = crc_next ^ COLS[i];
            end
        end
    end

`ifdef CRC_CHK_CALC_OUT_REG_EN
    logic [7:0] crc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_next;
        end
    end

    assign crc_out = crc_q;
`else
    // Combinational build: clk and reset are present only for port compatibility.
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign crc_out = crc_next;
`endif

endmodule

// File: tb/tb_crc8_chk_calc.sv
// tb/tb_crc8_chk_calc.sv - directed and exhaustive checks of crc8_chk_calc (either build of CRC_CHK_CALC_OUT_REG_EN)
module tb_crc8_chk_calc;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] crc_in = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic [7:0] crc_out;
    logic [7:0] crc_out_1d;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    crc8_chk_calc #(.POLY(8'h07)) dut (
        .clk(clk), .reset(reset), .crc_in(crc_in), .data_in(data_in), .crc_out(crc_out)
    );

    crc8_chk_calc #(.POLY(8'h1D)) dut_1d (
        .clk(clk), .reset(reset), .crc_in(crc_in), .data_in(data_in), .crc_out(crc_out_1d)
    );

    function automatic logic [7:0] ref_crc(input logic [7:0] c_in, input logic [7:0] d,
                                           input logic [7:0] poly);
        logic [7:0] c;
        c = c_in ^ d;
        for (int k = 0; k < 8; k++) begin
            if (c[7]) c = (c << 1) ^ poly;
            else      c = c << 1;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present one byte and wait until its result is visible on crc_out.
    task automatic apply(input logic [7:0] c, input logic [7:0] d);
        crc_in  = c;
        data_in = d;
`ifdef CRC_CHK_CALC_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    initial begin
        logic [7:0] stream [9];
        int         mism_07;
        int         mism_1d;

        for (int i = 0; i < 9; i++) stream[i] = 8'h31 + 8'(i);

`ifdef CRC_CHK_CALC_OUT_REG_EN
        reset = 1'b1;
        data_in = 8'h5A;
        @(posedge clk);
        #1;
        check("reset_state", crc_out, 8'h00);
        reset = 1'b0;
`else
        reset = 1'b1;
        apply(8'h00, 8'h01);
        check("reset_ignored", crc_out, 8'h07);
        reset = 1'b0;
`endif

        apply(8'h00, 8'h00); check("zero",        crc_out, 8'h00);
        apply(8'h00, 8'h01); check("single_bit",  crc_out, 8'h07);
        apply(8'h00, 8'hFF); check("full_byte",   crc_out, 8'hF3);
        apply(8'h07, 8'h00); check("sym_crc_07",  crc_out, 8'h15);
        apply(8'h01, 8'h01); check("sym_cancel",  crc_out, 8'h00);
        apply(8'h00, 8'h07); check("sym_data_07", crc_out, 8'h15);
        apply(8'h80, 8'h00); check("msb_only",    crc_out, 8'h89);
        apply(8'h00, 8'h01); check("poly1d_bit0", crc_out_1d, 8'h1D);

        apply(8'h00, stream[0]);
        for (int i = 1; i < 9; i++) apply(crc_out, stream[i]);
        check("stream_123456789", crc_out, 8'hF4);

        mism_07 = 0;
        mism_1d = 0;
        for (int n = 0; n < 65536; n++) begin
            apply(n[15:8], n[7:0]);
            if (crc_out !== ref_crc(n[15:8], n[7:0], 8'h07)) mism_07++;
            if (crc_out_1d !== ref_crc(n[15:8], n[7:0], 8'h1D)) mism_1d++;
        end
        check("exhaustive_poly07_mismatches", mism_07, 0);
        check("exhaustive_poly1d_mismatches", mism_1d, 0);

`ifdef CRC_CHK_CALC_OUT_REG_EN
        apply(8'h00, 8'h01);
        check("reg_latency", crc_out, 8'h07);
        reset = 1'b1;
        apply(8'h00, 8'hFF);
        check("reg_reset_wins", crc_out, 8'h00);
        reset = 1'b0;
        apply(8'h00, 8'hFF);
        check("reg_after_reset", crc_out, 8'hF3);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
